// File: rtl/seq_restoring_divider_pkg.sv
// rtl/seq_restoring_divider_pkg.sv - shared FSM encodings and sizing helper for the divider
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Step counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_addsub_stage.sv
// rtl/seq_restoring_divider_addsub_stage.sv - shared subtract stage, diff = a + ~b + 1
module div_addsub_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           neg
);

  always_comb begin
    diff = a + ~b + {{WIDTH{1'b0}}, 1'b1};
    neg  = diff[WIDTH];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// rtl/seq_restoring_divider.sv - multi-cycle unsigned restoring divider with start/done handshake
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state, state_next;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dreg;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   diff;
  logic             neg;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;
  logic             accept;
  logic             div_zero_in;
  logic             unused_r_msb;

  // A restored partial remainder is always below the divisor, so r[WIDTH] never feeds s.
  assign unused_r_msb = r[WIDTH];

  assign accept      = start && (state == ST_IDLE || state == ST_DONE);
  assign div_zero_in = (divisor == '0);

  div_addsub_stage #(.WIDTH(WIDTH)) u_stage (
    .a    (s),
    .b    ({1'b0, dreg}),
    .diff (diff),
    .neg  (neg)
  );

  always_comb begin
    s      = {r[WIDTH-1:0], q[WIDTH-1]};
    r_step = neg ? s : diff;
    q_step = {q[WIDTH-2:0], ~neg};
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = div_zero_in ? ST_DONE : ST_RUN;
      ST_RUN:  if (count == CW'(1)) state_next = ST_DONE;
      ST_DONE: begin
        if (start) state_next = div_zero_in ? ST_DONE : ST_RUN;
        else       state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      r           <= '0;
      q           <= '0;
      dreg        <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        r           <= '0;
        q           <= dividend;
        dreg        <= divisor;
        count       <= CW'(WIDTH);
        div_by_zero <= div_zero_in;
        if (div_zero_in) begin
          quotient  <= '1;
          remainder <= dividend;
        end
      end else if (state == ST_RUN) begin
        r     <= r_step;
        q     <= q_step;
        count <= count - CW'(1);
        // Results land only on the final step so they stay stable throughout RUN.
        if (count == CW'(1)) begin
          quotient  <= q_step;
          remainder <= r_step[WIDTH-1:0];
        end
      end
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb/tb_seq_restoring_divider.sv - directed self-checking bench for seq_restoring_divider
module tb_seq_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  seq_restoring_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulses start for one edge, then counts negedges until done (bounded).
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, output int lat, output int nbusy);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) break;
    end
  endtask

  int lat, nb, ndone;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dbz", div_by_zero, 0);

    run_op(4'd13, 4'd4, lat, nb);
    check("13/4_lat", lat, 5);
    check("13/4_busy", nb, 4);
    check("13/4_q", quotient, 3);
    check("13/4_r", remainder, 1);
    check("13/4_dbz", div_by_zero, 0);
    @(negedge clk);
    check("13/4_done_pulse", done, 0);

    run_op(4'd15, 4'd1, lat, nb);
    check("15/1_q", quotient, 15);
    check("15/1_r", remainder, 0);
    run_op(4'd7, 4'd9, lat, nb);
    check("7/9_q", quotient, 0);
    check("7/9_r", remainder, 7);
    run_op(4'd0, 4'd5, lat, nb);
    check("0/5_q", quotient, 0);
    check("0/5_r", remainder, 0);

    run_op(4'd9, 4'd0, lat, nb);
    check("9/0_lat", lat, 1);
    check("9/0_q", quotient, 15);
    check("9/0_r", remainder, 9);
    check("9/0_dbz", div_by_zero, 1);
    run_op(4'd6, 4'd3, lat, nb);
    check("6/3_q", quotient, 2);
    check("6/3_r", remainder, 0);
    check("6/3_dbz", div_by_zero, 0);

    // start pulsed during RUN must be ignored
    dividend = 4'd13; divisor = 4'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("ign_q_held", quotient, 2);
    dividend = 4'd5; divisor = 4'd2; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("ign_ndone", ndone, 1);
    check("ign_q", quotient, 3);
    check("ign_r", remainder, 1);

    // reset in the second RUN cycle aborts the operation
    dividend = 4'd13; divisor = 4'd4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_ndone", ndone, 0);
    check("abort_busy", busy, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dbz", div_by_zero, 0);
    run_op(4'd8, 4'd3, lat, nb);
    check("8/3_lat", lat, 5);
    check("8/3_q", quotient, 2);
    check("8/3_r", remainder, 2);

    // start held high through DONE: back-to-back accept
    dividend = 4'd11; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    #1 dividend = 4'd14; divisor = 4'd5;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    check("b2b_first_lat", lat, 5);
    check("b2b_first_q", quotient, 3);
    check("b2b_first_r", remainder, 2);
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check("b2b_busy", busy, 1);
      check("b2b_held", {quotient, remainder}, {4'd3, 4'd2});
    end
    @(negedge clk);
    check("b2b_done", done, 1);
    check("b2b_q", quotient, 2);
    check("b2b_r", remainder, 4);

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(4'(a), 4'(b), lat, nb);
        check("sweep_lat", lat, 5);
        check("sweep_inv", quotient * b + remainder, a);
        check("sweep_rem_lt", (remainder < b), 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
